// File: rtl/sfp_pkg.sv
// Shared definitions for the sfp controller slice.
//   - default widths for the input element, psum/threshold and length fields
//   - controller FSM state encoding
//   - small helper that picks the state that follows accumulation
package sfp_pkg;

  localparam int BW_DEF      = 4;   // input element width
  localparam int PSUM_BW_DEF = 16;  // psum / threshold width
  localparam int LEN_BW_DEF  = 8;   // accumulation length width

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    ACC  = 3'd2,
    RELU = 3'd3,
    OUT  = 3'd4
  } sfp_state_e;

  // After the psum is complete the job either takes the ReLU step or goes
  // straight to presenting the result.
  function automatic sfp_state_e post_acc_state(input logic relu);
    return relu ? RELU : OUT;
  endfunction

endpackage

// File: rtl/sfp_ctrl_if.sv
// Streaming and datapath-control bundle between sfp_ctrl and its parent.
//   in_valid/in_ready/in_data     : signed input beats into the controller
//   out_valid/out_ready/out_data  : result stream out of the controller
//   sfp_acc/sfp_relu/sfp_clr      : strobes to the sfp datapath
//   sfp_in/sfp_thres              : element and threshold to the datapath
//   sfp_out                       : psum returned by the datapath
// master = controller side, slave = parent/environment side.
interface sfp_ctrl_if
  import sfp_pkg::*;
#(
  parameter int bw      = BW_DEF,
  parameter int psum_bw = PSUM_BW_DEF
);

  logic               in_valid;
  logic               in_ready;
  logic [bw-1:0]      in_data;

  logic               out_valid;
  logic               out_ready;
  logic [psum_bw-1:0] out_data;

  logic               sfp_acc;
  logic               sfp_relu;
  logic               sfp_clr;
  logic [bw-1:0]      sfp_in;
  logic [psum_bw-1:0] sfp_thres;
  logic [psum_bw-1:0] sfp_out;

  modport master (
    input  in_valid, in_data, out_ready, sfp_out,
    output in_ready, out_valid, out_data,
           sfp_acc, sfp_relu, sfp_clr, sfp_in, sfp_thres
  );

  modport slave (
    output in_valid, in_data, out_ready, sfp_out,
    input  in_ready, out_valid, out_data,
           sfp_acc, sfp_relu, sfp_clr, sfp_in, sfp_thres
  );

endinterface

// File: rtl/sfp_ctrl.sv
// Sequencing controller for an external sfp (accumulate / threshold-ReLU)
// datapath. A job is requested with a one-cycle start in IDLE; the job
// parameters are latched at that point and held for the whole job.
// Flow: IDLE -> CLR (one cycle, clears the datapath) -> ACC (accept len
// beats, gaps allowed) -> RELU (optional, one cycle) -> OUT (hold result
// until accepted) -> IDLE, with done pulsing the cycle after the handshake.
// The controller never touches psum values; the datapath owns all
// arithmetic and sign extension.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start             : job request, looked at only while idle
//   len, relu_en,
//   thres_in          : job parameters, latched with start
//   busy              : high whenever not idle
//   done              : one-cycle completion pulse
//   bus (master)      : input/result streams and datapath controls
module sfp_ctrl
  import sfp_pkg::*;
#(
  parameter int bw      = BW_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int len_bw  = LEN_BW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  input  logic               relu_en,
  input  logic [psum_bw-1:0] thres_in,
  output logic               busy,
  output logic               done,
  sfp_ctrl_if.master         bus
);

  localparam logic [len_bw-1:0] len_one = len_bw'(1);

  sfp_state_e         state, state_n;

  logic [len_bw-1:0]  len_q;
  logic               relu_q;
  logic [psum_bw-1:0] thres_q;
  logic [len_bw-1:0]  cnt;
  logic [len_bw-1:0]  cnt_inc;
  logic               clr_q;
  logic               done_q;

  logic               beat;       // beat accepted this cycle
  logic               last_beat;  // accepted beat is the len-th one
  logic [bw-1:0]      elem;

  assign cnt_inc   = cnt + len_one;
  assign beat      = (state == ACC) && bus.in_valid;
  assign last_beat = beat && (cnt_inc == len_q);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = CLR;
      CLR: begin
        if (len_q != '0) state_n = ACC;
        else             state_n = post_acc_state(relu_q);
      end
      ACC:  if (last_beat) state_n = post_acc_state(relu_q);
      RELU: state_n = OUT;
      OUT:  if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ------------------------------------------- job parameters / counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q   <= '0;
      relu_q  <= 1'b0;
      thres_q <= '0;
      cnt     <= '0;
    end else begin
      // Only an idle controller takes a new job, so parameters stay
      // frozen for the job in flight even if start toggles.
      if ((state == IDLE) && start) begin
        len_q   <= len;
        relu_q  <= relu_en;
        thres_q <= thres_in;
      end
      if (state == CLR)  cnt <= '0;
      else if (beat)     cnt <= cnt_inc;
    end
  end

  // sfp_clr drives the datapath's asynchronous clear, so it comes straight
  // from a flop rather than from state decode. It is set on entry to CLR
  // and drops on the way out, which makes it exactly the CLR cycle.
  // done is likewise registered: the cycle after the OUT handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      clr_q  <= (state_n == CLR);
      done_q <= (state == OUT) && bus.out_ready;
    end
  end

  // ------------------------------------------------------------ outputs
  assign elem          = bus.in_data;
  assign busy          = (state != IDLE);
  assign done          = done_q;

  assign bus.in_ready  = (state == ACC);
  assign bus.sfp_acc   = beat;
  assign bus.sfp_relu  = (state == RELU);
  assign bus.sfp_clr   = clr_q;
  assign bus.sfp_in    = elem;
  assign bus.sfp_thres = thres_q;

  // The datapath holds its psum while no strobe is active, so passing it
  // through unmodified keeps out_data stable for as long as OUT lasts.
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = (state == OUT) ? bus.sfp_out : '0;

endmodule

// File: tb/tb_sfp_ctrl.sv
module tb_sfp_ctrl;
  import sfp_pkg::*;

  localparam int BW      = BW_DEF;
  localparam int PSUM_BW = PSUM_BW_DEF;
  localparam int LEN_BW  = LEN_BW_DEF;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [LEN_BW-1:0]  len;
  logic               relu_en;
  logic [PSUM_BW-1:0] thres_in;
  logic               busy, done;

  sfp_ctrl_if #(.bw(BW), .psum_bw(PSUM_BW)) bus();

  sfp_ctrl #(.bw(BW), .psum_bw(PSUM_BW), .len_bw(LEN_BW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .relu_en(relu_en),
    .thres_in(thres_in), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Stand-in sfp datapath: clear, accumulate sign-extended beats, threshold.
  logic signed [PSUM_BW-1:0] psum;
  always @(posedge clk or posedge reset or posedge bus.sfp_clr) begin
    if (reset || bus.sfp_clr) psum <= '0;
    else if (bus.sfp_acc)     psum <= psum + PSUM_BW'($signed(bus.sfp_in));
    else if (bus.sfp_relu && (psum < $signed(bus.sfp_thres))) psum <= '0;
  end
  assign bus.sfp_out = psum;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  // Model state for the job in flight.
  logic [PSUM_BW-1:0] exp_res, exp_thres, hs_res, held;
  int  acc_cnt, relu_cnt, done_cnt, first_ov;
  bit  prev_hs, prev_hold;
  int  beats[64];

  // Every-cycle comparison against the rules of the controller.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_outs", {25'd0, busy, done, bus.in_ready, bus.out_valid,
                       bus.sfp_acc, bus.sfp_relu, bus.sfp_clr}, 32'd0);
      chk("rst_thres", {16'd0, bus.sfp_thres}, 32'd0);
      prev_hs = 0; prev_hold = 0;
    end else begin
      chk("done_after_hs", {31'd0, done}, {31'd0, prev_hs});
      if (done) done_cnt++;
      chk("acc_strobe", {31'd0, bus.sfp_acc}, {31'd0, bus.in_valid & bus.in_ready});
      if (bus.sfp_acc) acc_cnt++;
      if (bus.sfp_relu) relu_cnt++;
      chk("idle_quiet", {31'd0, !busy && (bus.in_ready | bus.out_valid | bus.sfp_relu | bus.sfp_clr)}, 32'd0);
      chk("one_owner", $countones({bus.in_ready, bus.out_valid, bus.sfp_relu, bus.sfp_clr}) <= 1, 32'd1);
      chk("sfp_in", {28'd0, bus.sfp_in}, {28'd0, bus.in_data});
      if (busy) chk("thres_latched", {16'd0, bus.sfp_thres}, {16'd0, exp_thres});
      if (bus.out_valid) begin
        chk("out_data", {16'd0, bus.out_data}, {16'd0, exp_res});
        if (first_ov < 0) first_ov = cyc;
        if (bus.out_ready) hs_res = bus.out_data;
      end
      if (prev_hold) begin
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_data", {16'd0, bus.out_data}, {16'd0, held});
      end
      prev_hold = bus.out_valid & !bus.out_ready;
      held      = bus.out_data;
      prev_hs   = bus.out_valid & bus.out_ready;
    end
  end

  // gap < 0: random 0..3 idle cycles between beats; ordly >= 1: cycles
  // out_ready stays low in OUT; rst_after > 0: reset after that many beats.
  task automatic run_job(input int n, input bit relu, input int thres, input int gap,
                         input int ordly, input bit start_mid, input int rst_after);
    int sum, idx, g, wd, e0, ov_seen;
    bit fire, hsnow, hs, aborted;
    sum = 0;
    for (int i = 0; i < n; i++) sum += beats[i];
    exp_res   = (relu && sum < thres) ? '0 : PSUM_BW'(sum);
    exp_thres = PSUM_BW'(thres);
    acc_cnt = 0; relu_cnt = 0; done_cnt = 0; first_ov = -1; hs_res = 'x;
    @(posedge clk); #1;
    start = 1; len = LEN_BW'(n); relu_en = relu; thres_in = PSUM_BW'(thres);
    bus.in_valid = (n > 0); bus.in_data = BW'(beats[0]); bus.out_ready = 0;
    @(posedge clk); #1;
    e0 = cyc;
    // Scramble the request inputs: the job must keep what it latched.
    start = 0; len = LEN_BW'($urandom); relu_en = 1'($urandom); thres_in = PSUM_BW'($urandom);
    idx = 0; g = 0; wd = 0; ov_seen = 0; hs = 0; aborted = 0;
    while (!hs && !aborted && wd < 2000) begin
      @(negedge clk);
      fire  = bus.in_valid & bus.in_ready;
      hsnow = bus.out_valid & bus.out_ready;
      if (bus.out_valid) ov_seen++;
      @(posedge clk); #1;
      wd++;
      start = 0;
      if (hsnow) begin hs = 1; bus.out_ready = 0; end
      if (fire) begin
        idx++;
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        if (start_mid && idx == 1) begin
          start = 1; len = LEN_BW'(1); relu_en = 1; thres_in = 16'h7fff;
        end
        if (rst_after == idx) begin reset = 1; aborted = 1; end
      end
      if (idx < n && g == 0) begin
        bus.in_valid = 1; bus.in_data = BW'(beats[idx]);
      end else begin
        bus.in_valid = 0; bus.in_data = BW'($urandom);
        if (g > 0) g--;
      end
      if (!hs && ov_seen >= ordly) bus.out_ready = 1;
    end
    start = 0; bus.in_valid = 0; bus.out_ready = 0;
    if (aborted) begin
      @(posedge clk); #1; reset = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, 0);
      chk("abort_idle", {31'd0, busy}, 32'd0);
    end else begin
      chk("job_timeout", {31'd0, hs}, 32'd1);
      chk("acc_pulses", acc_cnt, n);
      chk("relu_pulses", relu_cnt, {31'd0, relu});
      chk("result", {16'd0, hs_res}, {16'd0, exp_res});
      if (gap == 0) chk("latency", first_ov - e0, n + 1 + int'(relu));
      repeat (2) @(posedge clk);
      #1;
      chk("done_once", done_cnt, 1);
      chk("back_idle", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    reset = 1; start = 0; len = '0; relu_en = 0; thres_in = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    exp_res = '0; exp_thres = '0; held = '0; hs_res = '0;
    acc_cnt = 0; relu_cnt = 0; done_cnt = 0; first_ov = -1;
    prev_hs = 0; prev_hold = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // 2 + 3 - 1 = 4, valid held high -> out_valid at E0+4
    beats[0] = 2; beats[1] = 3; beats[2] = -1;
    run_job(3, 0, 0, 0, 1, 0, 0);
    chk("lit_sum4", {16'd0, hs_res}, 32'd4);
    // thres 5 kills the psum of 4, thres 4 keeps it
    run_job(3, 1, 5, 0, 1, 0, 0);
    chk("lit_relu_t5", {16'd0, hs_res}, 32'd0);
    run_job(3, 1, 4, 0, 1, 0, 0);
    chk("lit_relu_t4", {16'd0, hs_res}, 32'd4);
    // two idle cycles between each beat
    beats[0] = 1; beats[1] = 1; beats[2] = 1; beats[3] = 1;
    run_job(4, 0, 0, 2, 1, 0, 0);
    chk("lit_gaps", {16'd0, hs_res}, 32'd4);
    // out_ready low for 3 cycles of OUT
    beats[0] = 5; beats[1] = -3;
    run_job(2, 0, 0, 0, 3, 0, 0);
    chk("lit_stall", {16'd0, hs_res}, 32'd2);
    // empty jobs
    run_job(0, 0, 0, 0, 1, 0, 0);
    chk("lit_len0", {16'd0, hs_res}, 32'd0);
    run_job(0, 1, -5, 0, 2, 0, 0);
    // start while busy is ignored
    beats[0] = 2; beats[1] = 3; beats[2] = -1;
    run_job(3, 0, 0, 0, 1, 1, 0);
    chk("lit_start_busy", {16'd0, hs_res}, 32'd4);
    // reset after 2 of 5 beats, then a fresh job
    beats[0] = 3; beats[1] = 3; beats[2] = 3; beats[3] = 3; beats[4] = 3;
    run_job(5, 0, 0, 0, 1, 0, 2);
    beats[0] = 7; beats[1] = 1;
    run_job(2, 0, 0, 0, 1, 0, 0);
    chk("lit_after_rst", {16'd0, hs_res}, 32'd8);

    // randomized jobs
    for (int j = 0; j < 25; j++) begin
      int n;
      n = int'($urandom_range(0, 12));
      for (int i = 0; i < n; i++) beats[i] = int'($urandom_range(0, 15)) - 8;
      run_job(n, 1'($urandom), int'($urandom_range(0, 40)) - 20,
              ($urandom_range(0, 1) == 1) ? -1 : 0, int'($urandom_range(1, 4)),
              (n >= 2) && ($urandom_range(0, 1) == 1), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
